// File: rtl/ring_freq_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// Build option: FREQ_METER_PERIOD_EN adds period measurement (ARM/MEAS states).
package ring_freq_meter_pkg;

  localparam int unsigned TAP_COUNT = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    GATE,
    ARM,
    MEAS,
    DONE
  } fm_state_t;

  // Cycles spent flushing the synchroniser after a tap change.
  function automatic int unsigned settle_len(input int unsigned sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser chain for one asynchronous tap, plus previous-value flop
// and a rising-edge flag (sync high while the delayed copy is still low).
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the tap through the synchroniser and keep one extra delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  // Rising edge seen at the synchroniser output.
  always_comb begin
    rise = chain[SYNC_STAGES-1] & ~prev;
  end

endmodule

// File: rtl/ring_freq_meter.sv
// Frequency meter for one tap of the ring-oscillator divider chain.
// Counts synchronised rising edges over a GATE_CYCLES window.
// Build option: FREQ_METER_PERIOD_EN adds the mode port and period measurement.
module ring_freq_meter
  import ring_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TAP_COUNT-1:0] taps,
  input  logic [2:0]           sel,
  input  logic                 start,
`ifdef FREQ_METER_PERIOD_EN
  input  logic                 mode,
`endif
  output logic                 busy,
  output logic [CNT_W-1:0]     count,
  output logic                 valid,
  output logic                 ovf
);

  localparam int unsigned SETTLE_LEN = settle_len(SYNC_STAGES);
  localparam int unsigned TMR_W      = $clog2(GATE_CYCLES + 1);
  localparam int unsigned SET_W      = $clog2(SETTLE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fm_state_t        state, state_next;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             rise;
`ifdef FREQ_METER_PERIOD_EN
  logic             mode_q;
`endif

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (taps[sel_q]),
    .rise(rise)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = SETTLE;
      SETTLE: if (set_q == SET_W'(SETTLE_LEN - 1)) begin
`ifdef FREQ_METER_PERIOD_EN
                state_next = mode_q ? ARM : GATE;
`else
                state_next = GATE;
`endif
              end
      GATE:   if (tmr_q == TMR_W'(GATE_CYCLES - 1)) state_next = DONE;
`ifdef FREQ_METER_PERIOD_EN
      ARM:    if (rise) state_next = MEAS;
              else if (cnt_q == CNT_MAX) state_next = DONE;
      MEAS:   if (cnt_q == CNT_MAX || rise) state_next = DONE;
`endif
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy  = (state != IDLE);
    valid = (state == DONE);
  end

  // Edge counter, window timer and settle timer updates.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    tmr_d = tmr_q;
    set_d = set_q;
    case (state)
      IDLE: if (start) begin
              cnt_d = '0;
              ovf_d = 1'b0;
              tmr_d = '0;
              set_d = '0;
            end
      SETTLE: set_d = set_q + 1'b1;
      GATE: begin
        tmr_d = tmr_q + 1'b1;
        if (rise) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef FREQ_METER_PERIOD_EN
      // ARM also counts clk cycles so a dead tap still terminates.
      ARM: begin
        if (rise)                 cnt_d = '0;
        else if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                      cnt_d = cnt_q + 1'b1;
      end
      // Counting includes the cycle of the closing edge, so count == period.
      MEAS: begin
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers; results are published on entry to DONE so that
  // count/ovf are already stable during the valid cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
`ifdef FREQ_METER_PERIOD_EN
      mode_q <= 1'b0;
`endif
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      tmr_q  <= '0;
      set_q  <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sel_q  <= sel;
`ifdef FREQ_METER_PERIOD_EN
        mode_q <= mode;
`endif
      end
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      tmr_q <= tmr_d;
      set_q <= set_d;
      if (state != DONE && state_next == DONE) begin
        count <= cnt_d;
        ovf   <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Self-checking bench for ring_freq_meter (GATE_CYCLES=100, SYNC_STAGES=2).
// A second instance with CNT_W=3 exercises saturation.
module tb_ring_freq_meter;
  import ring_freq_meter_pkg::*;

  localparam int G  = 100;
  localparam int S  = 2;
  localparam int W  = 16;
  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  taps;
  logic [2:0]  sel;
  logic        start, start_s;
  logic        busy, valid, ovf;
  logic [15:0] count;
  logic        busy_s, valid_s, ovf_s;
  logic [2:0]  count_s;
`ifdef FREQ_METER_PERIOD_EN
  logic        mode;
`endif

  always #5 clk = ~clk;

  ring_freq_meter #(.GATE_CYCLES(G), .CNT_W(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .taps(taps), .sel(sel), .start(start),
`ifdef FREQ_METER_PERIOD_EN
    .mode(mode),
`endif
    .busy(busy), .count(count), .valid(valid), .ovf(ovf)
  );

  ring_freq_meter #(.GATE_CYCLES(G), .CNT_W(WS), .SYNC_STAGES(S)) dut_sat (
    .clk(clk), .rst(rst), .taps(taps), .sel(sel), .start(start_s),
`ifdef FREQ_METER_PERIOD_EN
    .mode(mode),
`endif
    .busy(busy_s), .count(count_s), .valid(valid_s), .ovf(ovf_s)
  );

  int vectors = 0;
  int miscompares = 0;

  // Tap waveform generator: each tap has a high and low length in clk cycles
  // (0 = static). Every rising change is logged with the edge index it follows.
  int cyc = 0;
  int hi_len[8];
  int lo_len[8];
  int ph[8];
  int rise_q[8][$];

  initial begin
    taps = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 8; i++) begin
        if (hi_len[i] > 0) begin
          ph[i]++;
          if (ph[i] >= (taps[i] ? hi_len[i] : lo_len[i])) begin
            ph[i] = 0;
            taps[i] = ~taps[i];
            if (taps[i]) rise_q[i].push_back(cyc);
          end
        end
      end
    end
  end

  task automatic set_tap(input int i, input int h, input int phase);
    hi_len[i] = h;
    lo_len[i] = h;
    ph[i]     = phase;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: tap rises following edges N+1..N+G land in the gate window
  // (start sampled at edge N); the result saturates at the counter width.
  task automatic model(input int s, input int n, input int w, output int c, output bit o);
    int raw = 0;
    int mx  = (1 << w) - 1;
    for (int j = 0; j < rise_q[s].size(); j++)
      if (rise_q[s][j] >= n + 1 && rise_q[s][j] <= n + G) raw++;
    o = (raw > mx);
    c = o ? mx : raw;
  endtask

  logic [15:0] got_cnt;
  logic        got_ovf;

  task automatic measure(input bit sat, input logic [2:0] s, input string nm);
    int  n, c;
    bit  o, found;
    @(posedge clk); #2;
    sel = s;
    if (sat) start_s = 1'b1; else start = 1'b1;
    n = cyc + 1;
    @(posedge clk); #2;
    start = 1'b0; start_s = 1'b0;
    chk({nm, "_busy"}, sat ? busy_s : busy, 1);
    found = 0;
    for (int i = 0; i < G + 20; i++) begin
      @(negedge clk);
      if ((sat ? valid_s : valid) === 1'b1) begin found = 1; break; end
    end
    if (!found) begin
      chk({nm, "_timeout"}, 0, 1);
      got_cnt = '1; got_ovf = 1'bx;
      return;
    end
    chk({nm, "_latency"}, cyc - n, G + S + 1);
    model(s, n, sat ? WS : W, c, o);
    got_cnt = sat ? 16'(count_s) : count;
    got_ovf = sat ? ovf_s : ovf;
    chk({nm, "_cnt"}, got_cnt, c);
    chk({nm, "_ovf"}, got_ovf, o);
    @(negedge clk);
    chk({nm, "_busy_end"}, sat ? busy_s : busy, 0);
  endtask

  typedef struct {
    logic [2:0] s;
    int         h;
    bit         sat;
    int         exp_c;
    bit         exp_o;
    string      name;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, c;
    bit o;
    int vcyc[3];

    tbl[0] = '{3'd3, 5,  1'b0, 10, 1'b0, "freq_p10"};
    tbl[1] = '{3'd0, 2,  1'b0, 25, 1'b0, "fast_tap0"};
    tbl[2] = '{3'd7, 10, 1'b0, 5,  1'b0, "switch_p20"};
    tbl[3] = '{3'd2, 2,  1'b1, 7,  1'b1, "sat_p4"};
    tbl[4] = '{3'd1, 0,  1'b1, 0,  1'b0, "sat_quiet"};
    tbl[5] = '{3'd5, 25, 1'b0, 2,  1'b0, "freq_p50"};
    tbl[6] = '{3'd6, 50, 1'b1, 1,  1'b0, "sat_p100"};

    rst = 1'b1; start = 1'b0; start_s = 1'b0; sel = '0;
`ifdef FREQ_METER_PERIOD_EN
    mode = 1'b0;
`endif
    set_tap(0, 2, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int t = 0; t < 7; t++) begin
      if (tbl[t].s != 3'd0) set_tap(int'(tbl[t].s), tbl[t].h, 0);
      measure(tbl[t].sat, tbl[t].s, tbl[t].name);
      chk({tbl[t].name, "_tbl_cnt"}, got_cnt, tbl[t].exp_c);
      chk({tbl[t].name, "_tbl_ovf"}, got_ovf, tbl[t].exp_o);
    end

    // Reset 50 cycles into the gate window, then a clean rerun.
    set_tap(4, 5, 0);
    @(posedge clk); #2;
    sel = 3'd4; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (S + 1 + 50 - 1) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_count_sat", count_s, 0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (valid === 1'b1) nv++;
    end
    chk("midrst_no_valid", nv, 0);
    measure(1'b0, 3'd4, "post_rst");
    chk("post_rst_tbl_cnt", got_cnt, 10);

    // Start pulsed while busy is ignored.
    @(posedge clk); #2;
    sel = 3'd3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    nv = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (i == 40) start = 1'b1;
      if (i == 41) start = 1'b0;
      if (valid === 1'b1) nv++;
    end
    chk("busy_start_valids", nv, 1);

    // Start held high: back-to-back runs, one IDLE cycle between them.
    @(posedge clk); #2;
    sel = 3'd3; start = 1'b1;
    nv = 0;
    for (int i = 0; i < 400 && nv < 3; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        vcyc[nv] = cyc;
        model(3, cyc - (G + S + 1), W, c, o);
        chk("held_cnt", count, c);
        nv++;
        if (nv == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_runs", nv, 3);
    if (nv == 3) begin
      chk("held_gap1", vcyc[1] - vcyc[0], 105);
      chk("held_gap2", vcyc[2] - vcyc[1], 105);
    end
    @(negedge clk);
    chk("held_idle", busy, 0);

    // Randomised taps 2..7 (tap 1 stays quiet, tap 0 keeps toggling).
    for (int r = 0; r < 20; r++) begin
      for (int i = 2; i < 8; i++) begin
        int h;
        h = int'($urandom_range(30, 2));
        set_tap(i, h, int'($urandom_range(h - 1, 0)));
      end
      measure(1'($urandom_range(1, 0)), 3'($urandom_range(7, 2)), "rand");
    end

`ifdef FREQ_METER_PERIOD_EN
    // Period mode: asymmetric period-37 tap, then a dead tap.
    mode = 1'b1;
    hi_len[5] = 18; lo_len[5] = 19; ph[5] = 0;
    for (int k = 0; k < 2; k++) begin
      int lim;
      bit found;
      lim = (k == 0) ? 400 : 70000;
      @(posedge clk); #2;
      sel = (k == 0) ? 3'd5 : 3'd1; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      found = 0;
      for (int i = 0; i < lim; i++) begin
        @(negedge clk);
        if (valid === 1'b1) begin found = 1; break; end
      end
      chk(k == 0 ? "period_done" : "dead_done", found, 1);
      chk(k == 0 ? "period_cnt" : "dead_cnt", count, k == 0 ? 37 : 65535);
      chk(k == 0 ? "period_ovf" : "dead_ovf", ovf, k == 0 ? 0 : 1);
      @(negedge clk);
    end
    mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_freq_meter.md
# ring_freq_meter

Measures the frequency (and optionally the period) of one tap of the ring-oscillator divider chain in system-clock cycles. The eight divided taps arrive asynchronously; one is selected, synchronised and edge-detected, and its rising edges are counted over a fixed gate window. The block reads the divider outputs and reports a count with a one-cycle valid strobe.

## Interface
- GATE_CYCLES, 1000: gate window length in clk cycles, minimum 1.
- CNT_W, 16: width of `count`.
- SYNC_STAGES, 2: synchroniser depth, minimum 2.
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- taps  in  8  divider outputs `/2` through `/128`, plus the raw ring at index 0. These are asynchronous to clk.
- sel  in  3  tap index, latched at start.
- start  in  1  single-cycle request; ignored while `busy`.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- count  out  CNT_W  result; held until the next accepted start.
- valid  out  1  one-cycle strobe when `count` is updated.
- ovf  out  1  result saturated; held alongside `count`.
- mode  in  1  present only with FREQ_METER_PERIOD_EN: 0 = frequency, 1 = period. Latched at start.

## Operation
- Tap mux: selects `taps[sel_q]`. Its output feeds a SYNC_STAGES-flop synchroniser, then a previous-value flop. A rising edge is flagged when `sync=1` and `prev=0`.
- FSM states: IDLE, SETTLE, GATE, ARM (period mode only), MEAS (period mode only), DONE.
- IDLE: on `start`, latch `sel` (and `mode`), clear the edge counter and window timer, set `ovf_q=0`, and go to SETTLE.
- SETTLE: SYNC_STAGES+1 cycles. Edges are ignored here, which flushes stale data from the previously selected tap. Exit to GATE, or to ARM when `mode=1`.
- GATE: exactly GATE_CYCLES cycles. Each flagged edge increments the counter.
  - At all-ones the counter holds and `ovf_q` sets.
  - Exit to DONE.
- DONE: one cycle. Loads `count` and `ovf` from the internal registers, pulses `valid`, then returns to IDLE.
- Start handling:
  - A `start` asserted in DONE is ignored.
  - A `start` asserted in the same cycle the FSM enters IDLE is accepted on the next clk edge, once the FSM is in IDLE.
- Reset, including mid-measurement: FSM goes to IDLE. `busy=0`, `count=0`, `valid=0`, `ovf=0`. Synchroniser, prev flop, counters and latched sel/mode all clear to 0.
- Arithmetic: counter is unsigned CNT_W and saturating, never wrapping. Window timer width is $clog2(GATE_CYCLES+1).

## Timing
- Start sampled at edge N: `busy=1` from N+1.
- Frequency-mode latency: `valid` at cycle N+1+(SYNC_STAGES+1)+GATE_CYCLES; `busy` falls the cycle after.
- Edge-flag latency: SYNC_STAGES+1 clk cycles after the tap rises.
- Input requirement: the tap high and low phases must each be ≥2 clk cycles to be counted. Faster inputs alias; this is not detected.
- `count` and `ovf` change only in DONE.

## Configuration
- FREQ_METER_PERIOD_EN defined: adds the `mode` port and the ARM/MEAS states.
  - ARM waits for the first flagged edge, then goes to MEAS.
  - MEAS counts clk cycles until the next flagged edge, then goes to DONE. `count` equals the period in clk cycles.
  - If either ARM or MEAS reaches the all-ones cycle count, `ovf=1`, `count`=all-ones, and the FSM goes to DONE.
- FREQ_METER_PERIOD_EN undefined: no `mode` port, frequency mode only, ARM/MEAS logic absent.

## Structure
- Package `ring_freq_meter_pkg`:
  - state enum `fm_state_t`;
  - function returning the settle length (SYNC_STAGES+1);
  - constant `TAP_COUNT=8`.
- Sub-module `sync_edge_det` holds the synchroniser chain, prev flop and rise flag. It is parameterised by SYNC_STAGES and has async active-high reset.
- Tap mux, FSM, counters and output registers live in the top module.

## Test plan
Common parameters: GATE_CYCLES=100, CNT_W=16, SYNC_STAGES=2.
- Frequency count: `taps[3]` toggles every 5 clk (period 10), sel=3, start → `valid` 104 cycles after start, `count=10`, `ovf=0`.
- Tap switching: sel=7 with `taps[7]` at period 20, while `taps[0]` has been toggling fast beforehand → `count=5`. Edges from the previous tap are not counted.
- Saturation with CNT_W=3: tap period 4 (25 edges) → `count=7`, `ovf=1`. A following start on a quiet tap → `count=0`, `ovf=0`.
- Reset mid-measurement: assert rst at cycle 50 of GATE → all outputs 0 immediately. Next start yields a correct full count; no `valid` is produced from the aborted run.
- Start handling: start pulsed while busy → ignored, exactly one `valid`. Start held high continuously → back-to-back measurements, each `valid` separated by 105 cycles.
- Period mode (FREQ_METER_PERIOD_EN, mode=1): tap period 37 → `count=37`. Constant tap → `count=65535`, `ovf=1`.
